// File: rtl/dc_tag_ctrl.sv
//==============================================================================
// Module      : dc_tag_ctrl
// Description : DRAM-cache tag-lookup controller. Sweeps the tag memory to
//               invalid after reset, then serially pops requests from an FWFT
//               request FIFO, reads the tag entry of the addressed set,
//               resolves hit / miss / dirty-victim eviction, updates the tag
//               entry and presents one lookup result downstream.
//               Optional hit/miss statistics counters are built when the
//               macro DC_TAG_CTRL_STATS_EN is defined; otherwise the counter
//               ports are tied to zero.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module dc_tag_ctrl #(
    parameter  int ADDR_WIDTH   = 64,
    parameter  int ID_WIDTH     = 16,
    parameter  int INDEX_WIDTH  = 4,
    parameter  int OFFSET_WIDTH = 6,
    localparam int TAG_WIDTH    = ADDR_WIDTH - INDEX_WIDTH - OFFSET_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst_n,
    // Request FIFO (first-word-fall-through head)
    input  logic                           fifo_empty_i,
    input  logic [ADDR_WIDTH+ID_WIDTH:0]   fifo_data_i,
    output logic                           fifo_read_en_o,
    // Single-port tag memory
    output logic                           tag_rd_en_o,
    output logic                           tag_wr_en_o,
    output logic [INDEX_WIDTH-1:0]         tag_index_o,
    output logic [TAG_WIDTH+1:0]           tag_wdata_o,
    input  logic [TAG_WIDTH+1:0]           tag_rdata_i,
    // Status
    output logic                           init_done_o,
    // Lookup result
    output logic                           resp_valid_o,
    input  logic                           resp_ready_i,
    output logic                           resp_hit_o,
    output logic                           resp_write_o,
    output logic [ID_WIDTH-1:0]            resp_id_o,
    output logic [ADDR_WIDTH-1:0]          resp_addr_o,
    output logic                           resp_evict_o,
    output logic [ADDR_WIDTH-1:0]          resp_victim_addr_o,
    // Statistics
    output logic [31:0]                    hit_cnt_o,
    output logic [31:0]                    miss_cnt_o
);

    localparam logic [1:0] S_INIT    = 2'd0;
    localparam logic [1:0] S_IDLE    = 2'd1;
    localparam logic [1:0] S_COMPARE = 2'd2;
    localparam logic [1:0] S_RESP    = 2'd3;

    localparam logic [INDEX_WIDTH-1:0] INIT_LAST = {INDEX_WIDTH{1'b1}};

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]              state_q, state_d;
    logic [INDEX_WIDTH-1:0]  init_cnt_q, init_cnt_d;
    logic                    init_done_q;

    logic                    req_write_q;
    logic [ID_WIDTH-1:0]     req_id_q;
    logic [ADDR_WIDTH-1:0]   req_addr_q;
    logic [INDEX_WIDTH-1:0]  req_index_q;

    logic                    hit_q;
    logic                    evict_q;
    logic [ADDR_WIDTH-1:0]   victim_q;

    // -------------------------------------------------------------------------
    // FIFO head decode and tag compare
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0]   fifo_addr;
    logic [ID_WIDTH-1:0]     fifo_id;
    logic                    fifo_write;
    logic [INDEX_WIDTH-1:0]  fifo_index;
    logic                    pop;

    logic                    rd_valid;
    logic                    rd_dirty;
    logic [TAG_WIDTH-1:0]    rd_tag;
    logic [TAG_WIDTH-1:0]    req_tag;
    logic                    lookup_hit;
    logic                    lookup_evict;
    logic [ADDR_WIDTH-1:0]   victim_addr;

    assign fifo_addr  = fifo_data_i[ADDR_WIDTH-1:0];
    assign fifo_id    = fifo_data_i[ADDR_WIDTH +: ID_WIDTH];
    assign fifo_write = fifo_data_i[ADDR_WIDTH+ID_WIDTH];
    assign fifo_index = fifo_addr[OFFSET_WIDTH +: INDEX_WIDTH];

    // A pop is never issued while reset is asserted so the FIFO head is kept.
    assign pop = (state_q == S_IDLE) && !fifo_empty_i && rst_n;

    assign rd_valid = tag_rdata_i[TAG_WIDTH+1];
    assign rd_dirty = tag_rdata_i[TAG_WIDTH];
    assign rd_tag   = tag_rdata_i[TAG_WIDTH-1:0];
    assign req_tag  = req_addr_q[ADDR_WIDTH-1 -: TAG_WIDTH];

    assign lookup_hit   = rd_valid && (rd_tag == req_tag);
    assign lookup_evict = !lookup_hit && rd_valid && rd_dirty;
    assign victim_addr  = {rd_tag, req_index_q, {OFFSET_WIDTH{1'b0}}};

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: one request fully serialised through compare/resp
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:    if (init_cnt_q == INIT_LAST) state_d = S_IDLE;
            S_IDLE:    if (!fifo_empty_i)           state_d = S_COMPARE;
            S_COMPARE:                              state_d = S_RESP;
            S_RESP:    if (resp_ready_i)            state_d = S_IDLE;
            default:                                state_d = S_INIT;
        endcase
    end

    // FSM outputs: tag memory strobes, FIFO pop and result valid
    always_comb begin
        fifo_read_en_o = 1'b0;
        tag_rd_en_o    = 1'b0;
        tag_wr_en_o    = 1'b0;
        tag_index_o    = req_index_q;
        tag_wdata_o    = '0;
        resp_valid_o   = 1'b0;
        case (state_q)
            S_INIT: begin
                // Sweep writes all-zero (invalid) entries; suppressed in reset
                tag_wr_en_o = rst_n;
                tag_index_o = init_cnt_q;
            end
            S_IDLE: begin
                if (pop) begin
                    fifo_read_en_o = 1'b1;
                    tag_rd_en_o    = 1'b1;
                    tag_index_o    = fifo_index;
                end
            end
            S_COMPARE: begin
                if (rst_n) begin
                    if (!lookup_hit) begin
                        // Miss: allocate, dirty only if the request is a write
                        tag_wr_en_o = 1'b1;
                        tag_wdata_o = {1'b1, req_write_q, req_tag};
                    end else if (req_write_q && !rd_dirty) begin
                        // Write hit on a clean line: mark it dirty
                        tag_wr_en_o = 1'b1;
                        tag_wdata_o = {1'b1, 1'b1, req_tag};
                    end
                end
            end
            S_RESP: begin
                resp_valid_o = 1'b1;
            end
            default: begin
                tag_index_o = req_index_q;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Init sweep counter
    // -------------------------------------------------------------------------
    always_comb begin
        init_cnt_d = init_cnt_q;
        if (state_q == S_INIT) begin
            init_cnt_d = init_cnt_q + 1'b1;
        end
    end

    // Init counter and done flag; done stays set until the next reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_cnt_q  <= '0;
            init_done_q <= 1'b0;
        end else begin
            init_cnt_q <= init_cnt_d;
            if ((state_q == S_INIT) && (init_cnt_q == INIT_LAST)) begin
                init_done_q <= 1'b1;
            end
        end
    end

    // Request capture on pop and result capture in compare
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_write_q <= 1'b0;
            req_id_q    <= '0;
            req_addr_q  <= '0;
            req_index_q <= '0;
            hit_q       <= 1'b0;
            evict_q     <= 1'b0;
            victim_q    <= '0;
        end else begin
            if (pop) begin
                req_write_q <= fifo_write;
                req_id_q    <= fifo_id;
                req_addr_q  <= fifo_addr;
                req_index_q <= fifo_index;
            end
            if (state_q == S_COMPARE) begin
                hit_q    <= lookup_hit;
                evict_q  <= lookup_evict;
                victim_q <= lookup_evict ? victim_addr : '0;
            end
        end
    end

    assign init_done_o        = init_done_q;
    assign resp_hit_o         = hit_q;
    assign resp_write_o       = req_write_q;
    assign resp_id_o          = req_id_q;
    assign resp_addr_o        = req_addr_q;
    assign resp_evict_o       = evict_q;
    assign resp_victim_addr_o = victim_q;

    // -------------------------------------------------------------------------
    // Optional statistics
    // -------------------------------------------------------------------------
`ifdef DC_TAG_CTRL_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    // Saturating hit/miss counters, one update per compare cycle
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (state_q == S_COMPARE) begin
            if (lookup_hit && (hit_cnt_q != 32'hFFFF_FFFF)) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (!lookup_hit && (miss_cnt_q != 32'hFFFF_FFFF)) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_cnt_o  = hit_cnt_q;
    assign miss_cnt_o = miss_cnt_q;
`else
    assign hit_cnt_o  = 32'd0;
    assign miss_cnt_o = 32'd0;
`endif

endmodule

`default_nettype wire

// File: doc/dc_tag_ctrl.md
# dc_tag_ctrl

Tag-lookup controller for the DRAM cache, sitting between the request FIFO (filled by the AR/AW index extractor) and the single-port tag memory. It pops one request at a time, reads the tag entry at the request's set index, decides hit/miss and dirty-victim eviction, updates the tag entry, and presents one lookup result per request downstream. After reset it initialises every tag entry to invalid before accepting requests.

## Interface
- ADDR_WIDTH, 64, request address width
- ID_WIDTH, 16, AXI ID width
- INDEX_WIDTH, 4, set index width; tag memory depth 2^INDEX_WIDTH
- OFFSET_WIDTH, 6, line offset width (64 B lines)
- TAG_WIDTH, ADDR_WIDTH-INDEX_WIDTH-OFFSET_WIDTH, derived localparam

Reset is `rst_n`: synchronous, active-low. The clock is `clk`.

- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- fifo_empty_i  in  1  request FIFO empty
- fifo_data_i  in  81  first-word-fall-through head: [80] write, [79:64] id, [63:0] addr
- fifo_read_en_o  out  1  pop head this cycle
- tag_rd_en_o  out  1  tag read strobe
- tag_wr_en_o  out  1  tag write strobe
- tag_index_o  out  INDEX_WIDTH  tag memory address
- tag_wdata_o  out  TAG_WIDTH+2  {valid, dirty, tag}
- tag_rdata_i  in  TAG_WIDTH+2  {valid, dirty, tag}, valid 1 cycle after tag_rd_en_o
- init_done_o  out  1  tag sweep complete
- resp_valid_o  out  1  lookup result valid
- resp_ready_i  in  1  downstream accepts result
- resp_hit_o  out  1  hit
- resp_write_o  out  1  request was a write
- resp_id_o  out  ID_WIDTH  request id
- resp_addr_o  out  ADDR_WIDTH  request address
- resp_evict_o  out  1  miss displaced a valid dirty line
- resp_victim_addr_o  out  ADDR_WIDTH  {old tag, index, OFFSET_WIDTH zeros}; 0 when !resp_evict_o
- hit_cnt_o  out  32  hit counter
- miss_cnt_o  out  32  miss counter

## Operation
- Address split: index = addr[OFFSET_WIDTH +: INDEX_WIDTH]; tag = addr[ADDR_WIDTH-1 -: TAG_WIDTH].
- States: S_INIT, S_IDLE, S_COMPARE, S_RESP.
- S_INIT: entered on reset. Each cycle, tag_wr_en_o=1, tag_wdata_o=0, tag_index_o=counter (0 up to 2^INDEX_WIDTH-1). After the last index, init_done_o=1 and the FSM moves to S_IDLE.
- S_IDLE: if !fifo_empty_i, fifo_read_en_o=1 and tag_rd_en_o=1 combinationally, with tag_index_o taken from fifo_data_i. The request is latched into internal registers and the FSM moves to S_COMPARE. Otherwise it stays in S_IDLE.
- S_COMPARE:
  - hit = rdata.valid && rdata.tag == req tag.
  - Read hit: no tag write.
  - Write hit: tag_wr_en_o=1 with {1,1,tag} only if rdata.dirty=0.
  - Miss: tag_wr_en_o=1 with {1, write, req tag}; evict = rdata.valid && rdata.dirty.
  - Result registers are loaded, then the FSM moves to S_RESP.
- S_RESP: resp_valid_o=1. All resp_* outputs stay stable until resp_ready_i=1, then the FSM moves to S_IDLE.
- Requests are fully serialised. No same-index hazard exists.
- tag_index_o holds the latched index outside S_INIT/S_IDLE-pop. It is 0 at reset.

## Timing
- Reset values: every output is 0 (init_done_o=0, resp_valid_o=0, counters 0).
- Latency: pop at cycle T, tag write (if any) at T+1, resp_valid_o high at T+2.
- Maximum throughput is 1 request per 3 cycles when resp_ready_i is held high.
- Init takes exactly 2^INDEX_WIDTH cycles. No fifo_read_en_o is issued before init_done_o=1.
- No pop happens while resp_valid_o is high: fifo_read_en_o=0 in S_COMPARE/S_RESP.
- fifo_empty_i rising in the pop cycle is not possible under FWFT. fifo_read_en_o is never asserted when fifo_empty_i=1.
- Reset mid-operation: the in-flight request is dropped and resp_valid_o drops on the next cycle. No tag write other than the init sweep occurs, and the sweep restarts from index 0.
- tag_rd_en_o and tag_wr_en_o are never both high in the same cycle.

## Configuration
- DC_TAG_CTRL_STATS_EN defined: hit_cnt_o/miss_cnt_o increment by 1 on each S_COMPARE hit/miss. They saturate at 32'hFFFF_FFFF and are cleared by reset.
- Not defined: counters are not synthesised; hit_cnt_o and miss_cnt_o are tied to 0. The ports remain.

## Test plan
- Reset, FIFO empty → 16 consecutive tag writes, indices 0..15, wdata 0, then init_done_o=1; no fifo_read_en_o during the sweep.
- Cold read 0x1040, id 3 → index 1, tag 4, miss; tag write {1,0,4} at index 1; resp_hit_o=0, resp_evict_o=0, resp_id_o=3, resp_valid_o 2 cycles after pop.
- Then write 0x1040, id 7 → hit; tag write {1,1,4}; resp_hit_o=1, resp_write_o=1. Then a second write to 0x1040 → hit, no tag write.
- Then read 0x2040 → index 1, tag 8, miss; resp_evict_o=1, resp_victim_addr_o=0x1040; tag write {1,0,8}.
- resp_ready_i low for 5 cycles with FIFO non-empty → resp_* outputs stable, fifo_read_en_o=0 throughout; the pop occurs the cycle after the handshake.
- With DC_TAG_CTRL_STATS_EN, after the above sequence: hit_cnt_o=2, miss_cnt_o=2. Forcing a counter to 32'hFFFF_FFFF holds it there. Reset during S_RESP → resp_valid_o=0 and the sweep restarts at index 0.
